game_seq_ctrl: RTL and testbench

GAME_SEQ_CTRL -- requirements
Module: game_seq_ctrl

---
 rtl/game_seq_ctrl.sv | 156 +++++++++++++++
 tb/tb_game_seq_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/game_seq_ctrl.sv
// Round sequencer for the runner game: tick generation, BCD scoring, speed-up.
// Optional macro HISCORE_TRACK_EN enables best-score tracking on hi_score.
module game_seq_ctrl #(
  parameter int INIT_PERIOD = 400000,
  parameter int MIN_PERIOD  = 150000,
  parameter int PERIOD_STEP = 10000,
  parameter int SCORE_DIV   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_key,
  input  logic        collide,
  output logic        game_tick,
  output logic        obj_rst,
  output logic [1:0]  game_state,
  output logic [15:0] score,
  output logic [15:0] hi_score
);

  // START shares game_state code 01 with RUN; 3-bit encoding keeps 2'b11 free
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    RUN   = 3'b001,
    OVER  = 3'b010,
    START = 3'b101
  } state_e;

  state_e      state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] period_q, period_d;
  logic [7:0]  div_q, div_d;
  logic [15:0] score_q, score_d;
  logic        tick_q, tick_d;
  logic        objrst_q, objrst_d;
  logic [15:0] score_inc;

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        c;
    r = s;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (s[4*i +: 4] == 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = s[4*i +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign score_inc = bcd_inc(score_q);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    div_d    = div_q;
    score_d  = score_q;
    tick_d   = 1'b0;
    objrst_d = 1'b0;
    case (state_q)
      IDLE, OVER: begin
        if (start_key) begin
          state_d  = START;
          objrst_d = 1'b1;
          cnt_d    = '0;
          div_d    = '0;
          score_d  = '0;
          period_d = 20'(INIT_PERIOD);
        end
      end
      // The START cycle counts toward the first period so the first tick
      // lands exactly period cycles after START.
      START: begin
        state_d = RUN;
        cnt_d   = 20'd1;
      end
      RUN: begin
        if (collide) begin
          state_d = OVER;
        end else if (cnt_q == period_q - 20'd1) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          if (div_q == 8'(SCORE_DIV - 1)) begin
            div_d = '0;
            if (score_q != 16'h9999) begin
              score_d = score_inc;
              if (score_inc[7:0] == 8'h00) begin
                if ({1'b0, period_q} >= 21'(MIN_PERIOD + PERIOD_STEP))
                  period_d = period_q - 20'(PERIOD_STEP);
                else
                  period_d = 20'(MIN_PERIOD);
              end
            end
          end else begin
            div_d = div_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 20'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      period_q <= 20'(INIT_PERIOD);
      div_q    <= '0;
      score_q  <= '0;
      tick_q   <= 1'b0;
      objrst_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      div_q    <= div_d;
      score_q  <= score_d;
      tick_q   <= tick_d;
      objrst_q <= objrst_d;
    end
  end

`ifdef HISCORE_TRACK_EN
  logic [15:0] hi_q;
  // Packed BCD orders the same as unsigned binary, so a plain compare works.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      hi_q <= '0;
    else if (state_q == RUN && collide && score_q > hi_q)
      hi_q <= score_q;
  end
  assign hi_score = hi_q;
`else
  assign hi_score = 16'h0000;
`endif

  always_comb begin
    case (state_q)
      RUN, START: game_state = 2'b01;
      OVER:       game_state = 2'b10;
      default:    game_state = 2'b00;
    endcase
  end

  assign game_tick = tick_q;
  assign obj_rst   = objrst_q;
  assign score     = score_q;

endmodule

// File: tb/tb_game_seq_ctrl.sv
// Directed bench for game_seq_ctrl: two instances (score divider 2 and 1)
// share clock and reset; expected values go through a FIFO scoreboard.
module tb_game_seq_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic st_a = 1'b0, co_a = 1'b0, st_b = 1'b0, co_b = 1'b0;
  logic gt_a, or_a, gt_b, or_b;
  logic [1:0]  gs_a, gs_b;
  logic [15:0] sc_a, hi_a, sc_b, hi_b;

`ifdef HISCORE_TRACK_EN
  localparam bit HI_EN = 1'b1;
`else
  localparam bit HI_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  game_seq_ctrl #(.INIT_PERIOD(10), .MIN_PERIOD(4), .PERIOD_STEP(3), .SCORE_DIV(2)) u_a (
    .clk(clk), .rst(rst), .start_key(st_a), .collide(co_a), .game_tick(gt_a),
    .obj_rst(or_a), .game_state(gs_a), .score(sc_a), .hi_score(hi_a));

  game_seq_ctrl #(.INIT_PERIOD(10), .MIN_PERIOD(4), .PERIOD_STEP(3), .SCORE_DIV(1)) u_b (
    .clk(clk), .rst(rst), .start_key(st_b), .collide(co_b), .game_tick(gt_b),
    .obj_rst(or_b), .game_state(gs_b), .score(sc_b), .hi_score(hi_b));

  int n_tests = 0, n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic [31:0] v);
    exp_q.push_back(v);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = exp_q.pop_front();
    n_tests++;
    assert (obs === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, e);
    end
  endtask

  // Cycles until the next game_tick on the selected instance (100 = timeout).
  task automatic ticks(input bit sel, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!(sel ? gt_b : gt_a) && n < 100);
  endtask

  task automatic wait_score(input bit sel, input logic [15:0] t, input int bound);
    int n;
    n = 0;
    while ((sel ? sc_b : sc_a) !== t && n < bound) begin
      step();
      n++;
    end
  endtask

  task automatic start_a();
    st_a = 1'b1; step(); st_a = 1'b0;
  endtask

  task automatic end_a();
    co_a = 1'b1; step(); co_a = 1'b0;
  endtask

  initial begin
    int n;
    logic [15:0] sc_save;

    // reset state
    step(); step();
    push(0); chk("rst_state", {30'd0, gs_a});
    push(0); chk("rst_tick", {31'd0, gt_a});
    push(0); chk("rst_objrst", {31'd0, or_a});
    push(0); chk("rst_score", {16'd0, sc_a});
    push(0); chk("rst_hi", {16'd0, hi_a});
    rst = 1'b0;

    // start at cycle 5, START at 6, first tick at 16, then every 10
    repeat (4) step();
    start_a();
    push(1); chk("start_objrst", {31'd0, or_a});
    push(1); chk("start_state", {30'd0, gs_a});
    push(0); chk("start_score", {16'd0, sc_a});
    ticks(0, n);
    push(10); chk("first_tick_lat", n);
    push(0); chk("objrst_cleared", {31'd0, or_a});
    push(16'h0000); chk("score_1tick", {16'd0, sc_a});
    ticks(0, n);
    push(10); chk("tick_period", n);
    push(16'h0001); chk("score_2ticks", {16'd0, sc_a});
    ticks(0, n);
    push(10); chk("tick_period3", n);

    // collide lands on the cycle where the 4th tick and a score point are due
    repeat (9) step();
    sc_save = sc_a;
    end_a();
    push(0); chk("collide_no_tick", {31'd0, gt_a});
    push(2); chk("collide_over", {30'd0, gs_a});
    push(sc_save); chk("collide_score", {16'd0, sc_a});
    co_a = 1'b1;
    repeat (3) step();
    co_a = 1'b0;
    push(2); chk("over_holds", {30'd0, gs_a});
    push(16'h0001); chk("over_score_frozen", {16'd0, sc_a});
    push(HI_EN ? 16'h0001 : 16'h0000); chk("hi_round0", {16'd0, hi_a});

    // restart from OVER, round ending at 0042
    start_a();
    push(1); chk("restart_objrst", {31'd0, or_a});
    push(16'h0000); chk("restart_score", {16'd0, sc_a});
    wait_score(0, 16'h0042, 2000);
    push(16'h0042); chk("reach_42", {16'd0, sc_a});
    end_a();
    push(2); chk("over_42", {30'd0, gs_a});
    push(HI_EN ? 16'h0042 : 16'h0000); chk("hi_after_42", {16'd0, hi_a});

    // lower-scoring round must not overwrite hi_score
    start_a();
    wait_score(0, 16'h0017, 1000);
    push(16'h0017); chk("reach_17", {16'd0, sc_a});
    end_a();
    push(16'h0017); chk("score_17_frozen", {16'd0, sc_a});
    push(HI_EN ? 16'h0042 : 16'h0000); chk("hi_after_17", {16'd0, hi_a});

    // asynchronous reset between edges mid-RUN
    start_a();
    repeat (25) step();
    #1 rst = 1'b1;
    #1;
    push(0); chk("arst_state", {30'd0, gs_a});
    push(0); chk("arst_tick", {31'd0, gt_a});
    push(0); chk("arst_objrst", {31'd0, or_a});
    push(0); chk("arst_score", {16'd0, sc_a});
    push(0); chk("arst_hi", {16'd0, hi_a});
    step();
    rst = 1'b0;
    st_a = 1'b1; step(); st_a = 1'b0;
    push(1); chk("start_after_rst", {31'd0, or_a});

    // speed-up steps 10 -> 7 -> 4 -> 4 on instance B
    st_b = 1'b1; step(); st_b = 1'b0;
    wait_score(1, 16'h0099, 2000);
    push(16'h0099); chk("reach_99", {16'd0, sc_b});
    ticks(1, n);
    push(10); chk("period_before_100", n);
    push(16'h0100); chk("score_100", {16'd0, sc_b});
    ticks(1, n);
    push(7); chk("period_after_100", n);
    wait_score(1, 16'h0200, 2000);
    ticks(1, n);
    push(4); chk("period_after_200", n);
    wait_score(1, 16'h0300, 2000);
    ticks(1, n);
    push(4); chk("period_clamped_300", n);

    // saturation at 9999
    wait_score(1, 16'h9999, 45000);
    push(16'h9999); chk("reach_9999", {16'd0, sc_b});
    ticks(1, n);
    push(4); chk("sat_period1", n);
    push(16'h9999); chk("sat_score1", {16'd0, sc_b});
    ticks(1, n);
    push(4); chk("sat_period2", n);
    push(16'h9999); chk("sat_score2", {16'd0, sc_b});
    push(0); chk("hi_b_unscored", {16'd0, hi_b});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
